// File: rtl/eq_frame_scheduler.sv
// Equalizer frame scheduler: feeds one sample per frame to a tapped filter
// bank, collects its output and hands gain updates over on frame boundaries.
module eq_frame_scheduler #(
    parameter int SAMPLE_BITS     = 16,
    parameter int NUMBER_OF_BANDS = 8,
    parameter int GAIN_BITS       = 2,
    parameter int NUMBER_OF_TAPS  = 64,
    parameter int FILTER_LATENCY  = 2,
    localparam int BAND_W = (NUMBER_OF_BANDS > 1) ? $clog2(NUMBER_OF_BANDS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    input  logic [SAMPLE_BITS-1:0]               s_data,
    output logic                                 s_ready,
    output logic                                 m_valid,
    output logic [SAMPLE_BITS-1:0]               m_data,
    input  logic                                 m_ready,
    input  logic                                 cfg_we,
    input  logic [BAND_W-1:0]                    cfg_band,
    input  logic [GAIN_BITS-1:0]                 cfg_gain,
    input  logic                                 cfg_amp_en,
    input  logic                                 cfg_commit,
    output logic                                 cfg_pending,
    output logic                                 fe_clk_enable,
    output logic [SAMPLE_BITS-1:0]               fe_filter_in,
    output logic                                 fe_amp_enable,
    output logic [NUMBER_OF_BANDS*GAIN_BITS-1:0] fe_gains,
    input  logic [SAMPLE_BITS-1:0]               fe_filter_out,
    output logic                                 busy,
    output logic [15:0]                          frame_count
);

    localparam int CNT_W = $clog2(NUMBER_OF_TAPS + 16);
    localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(NUMBER_OF_TAPS - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(FILTER_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, SETTLE, OUT} state_t;

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic accept, capture, handoff;

    logic [NUMBER_OF_BANDS*GAIN_BITS-1:0] shadow_gains, gains_nx;
    logic shadow_amp, amp_nx, pend_nx;
    logic [31:0] band_ext;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nx      = state;
        s_ready       = 1'b0;
        fe_clk_enable = 1'b0;
        busy          = 1'b1;
        accept        = 1'b0;
        capture       = 1'b0;
        handoff       = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                fe_clk_enable = 1'b1;
                if (cnt == TAP_LAST) state_nx = SETTLE;
            end
            SETTLE: begin
                if (cnt == SET_LAST) begin
                    capture  = 1'b1;
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    handoff  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Cycle counter, restarted on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state_nx != state || state == IDLE || state == OUT)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Sample hold, result register and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_filter_in <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            frame_count  <= '0;
        end else begin
            if (accept) fe_filter_in <= s_data;
            if (capture) begin
                m_data      <= fe_filter_out;
                m_valid     <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (handoff) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign band_ext = 32'(cfg_band);

    // Shadow settings as they stand after this cycle's write and commit
    always_comb begin
        gains_nx = shadow_gains;
        for (int b = 0; b < NUMBER_OF_BANDS; b++) begin
            if (cfg_we && band_ext == 32'(b))
                gains_nx[b*GAIN_BITS +: GAIN_BITS] = cfg_gain;
        end
        amp_nx  = cfg_commit ? cfg_amp_en : shadow_amp;
        pend_nx = cfg_pending | cfg_commit;
    end

    // Shadow storage and hand-over to the active set while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_gains  <= '0;
            shadow_amp    <= 1'b0;
            cfg_pending   <= 1'b0;
            fe_gains      <= '0;
            fe_amp_enable <= 1'b0;
        end else begin
            shadow_gains <= gains_nx;
            shadow_amp   <= amp_nx;
            if (state == IDLE && pend_nx) begin
                fe_gains      <= gains_nx;
                fe_amp_enable <= amp_nx;
                cfg_pending   <= 1'b0;
            end else begin
                cfg_pending <= pend_nx;
            end
        end
    end

endmodule
